// File: rtl/demux_stage_if.sv
// Handshake bundle for demux_stage: one input channel (data+select) and NOUT output channels.
// Latency: none, wiring only.
// Backpressure: carries in_ready and the per-channel out_ready vector; master = environment, slave = demux.
interface demux_stage_if #(
    parameter int WIDTH = 32,
    parameter int NOUT  = 2,
    parameter int SEL_W = 3
);
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [NOUT-1:0]  out_valid;
    logic [NOUT-1:0]  out_ready;
    logic [7:0]       drop_cnt;

    // Producer/consumer side: drives the input word and the consumer ready bits.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );

    // Demux side.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );
endinterface

// File: rtl/demux_stage.sv
// Registered 1-to-NOUT demux: routes each accepted word to the channel named by in_sel, drops out-of-range selects.
// Latency: one cycle from input transfer to out_valid/out_data.
// Backpressure: a stalled held channel blocks all input; DEMUX_STAGE_SKID_EN adds a skid entry and a registered in_ready.
//
// Ports: clk, rst_n (async active-low); bus (demux_stage_if.slave) carries in_data/in_sel/in_valid/in_ready,
// out_data/out_valid/out_ready and the saturating drop_cnt.
module demux_stage #(
    parameter int WIDTH = 32,
    parameter int NOUT  = 2,
    parameter int SEL_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    demux_stage_if.slave bus
);

`ifdef DEMUX_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
`else
    typedef enum logic {EMPTY, FULL} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [NOUT-1:0]  out_valid_q, out_valid_d;   // one-hot copy of the held select
    logic [7:0]       drop_cnt_q, drop_cnt_d;

`ifdef DEMUX_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [NOUT-1:0]  skid_vld_q, skid_vld_d;
    logic             in_ready_q, in_ready_d;
`endif

    logic [NOUT-1:0]  in_oh;
    logic             in_rdy;
    logic             in_fire;
    logic             in_hit;
    logic             out_fire;

    // Decode the select; an out-of-range select leaves in_oh all zero.
    always_comb begin
        in_oh = '0;
        for (int i = 0; i < NOUT; i++) begin
            if (bus.in_sel == i[SEL_W-1:0]) begin
                in_oh[i] = 1'b1;
            end
        end
    end

    // Only the held channel's ready can complete an output transfer.
    assign out_fire = |(out_valid_q & bus.out_ready);

`ifdef DEMUX_STAGE_SKID_EN
    assign in_rdy = in_ready_q;
`else
    assign in_rdy = (state_q == EMPTY) || out_fire;
`endif

    assign in_fire = bus.in_valid && in_rdy;
    assign in_hit  = in_fire && (|in_oh);

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop_cnt_d  = drop_cnt_q;
`ifdef DEMUX_STAGE_SKID_EN
        skid_data_d = skid_data_q;
        skid_vld_d  = skid_vld_q;
`endif

        // Dropped words are still consumed from the input; only the counter moves.
        if (in_fire && !(|in_oh) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        case (state_q)
            EMPTY: begin
                if (in_hit) begin
                    out_data_d  = bus.in_data;
                    out_valid_d = in_oh;
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (out_fire && in_hit) begin
                    out_data_d  = bus.in_data;
                    out_valid_d = in_oh;
                end else if (out_fire) begin
                    out_valid_d = '0;
                    state_d     = EMPTY;
                end
`ifdef DEMUX_STAGE_SKID_EN
                else if (in_hit) begin
                    skid_data_d = bus.in_data;
                    skid_vld_d  = in_oh;
                    state_d     = SKID;
                end
`endif
            end
`ifdef DEMUX_STAGE_SKID_EN
            SKID: begin
                // in_ready is low here, so only the head can move.
                if (out_fire) begin
                    out_data_d  = skid_data_q;
                    out_valid_d = skid_vld_q;
                    skid_vld_d  = '0;
                    state_d     = FULL;
                end
            end
`endif
            default: begin
                state_d     = EMPTY;
                out_valid_d = '0;
            end
        endcase

`ifdef DEMUX_STAGE_SKID_EN
        in_ready_d = (state_d != SKID);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_valid_q <= '0;
            drop_cnt_q  <= '0;
`ifdef DEMUX_STAGE_SKID_EN
            skid_data_q <= '0;
            skid_vld_q  <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef DEMUX_STAGE_SKID_EN
            skid_data_q <= skid_data_d;
            skid_vld_q  <= skid_vld_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stage.sv
// Bench for demux_stage: random and directed traffic scored against an in-order queue model.
// Latency: model expects each accepted word on the output one cycle after acceptance.
// Backpressure: random per-channel out_ready; model capacity is one word (two with DEMUX_STAGE_SKID_EN).
module tb_demux_stage;
    localparam int WIDTH = 32;
    localparam int NOUT  = 2;
    localparam int SEL_W = 3;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
    } ent_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   drop_model;
    int   n_out;
    logic mon_en;
    logic popped;
    ent_t exp_q[$];

    demux_stage_if #(.WIDTH(WIDTH), .NOUT(NOUT), .SEL_W(SEL_W)) bus ();

    demux_stage #(.WIDTH(WIDTH), .NOUT(NOUT), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_drop();
        return (drop_model > 255) ? 8'd255 : drop_model[7:0];
    endfunction

    // Monitor: compares every presented output against the head of the model queue.
    always @(negedge clk) begin
        logic [NOUT-1:0] ev;
        popped = 1'b0;
        if (mon_en) begin
            ev = '0;
            if (exp_q.size() != 0) ev[exp_q[0].sel] = 1'b1;
            chk("out_valid", 64'(bus.out_valid), 64'(ev));
            if (ev != '0) chk("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
            chk("drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop()));
            if ((ev & bus.out_ready) != '0) begin
                void'(exp_q.pop_front());
                popped = 1'b1;
                n_out++;
            end
        end
    end

    // One cycle of stimulus; the accepted word (if any) is pushed to the model.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s,
                        input logic [NOUT-1:0] r, output logic fired);
        logic exp_rdy;
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.out_ready = r;
        @(negedge clk);
        #1;
`ifdef DEMUX_STAGE_SKID_EN
        exp_rdy = ((exp_q.size() + int'(popped)) < 2);
`else
        exp_rdy = (exp_q.size() == 0);
`endif
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        fired = v && bus.in_ready;
        if (fired) begin
            if (int'(s) < NOUT) begin
                exp_q.push_back('{data: d, sel: s});
            end else begin
                drop_model++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             f;
        logic             pend;
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
        logic [NOUT-1:0]  r;
        int               out_start;

        errors = 0; checks = 0; drop_model = 0; n_out = 0;
        mon_en = 1'b0; popped = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0; bus.out_ready = '0;
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;

        // Basic routing.
        step(1'b1, 32'hDEADBEEF, 3'd1, 2'b11, f);
        step(1'b1, 32'h00000001, 3'd0, 2'b11, f);
        step(1'b0, '0, '0, 2'b11, f);
        step(1'b0, '0, '0, 2'b11, f);

        // Streaming: 16 back-to-back words alternating channels.
        out_start = n_out;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h1000 + 32'(i), SEL_W'(i % 2), 2'b11, f);
        end
        step(1'b0, '0, '0, 2'b11, f);
        step(1'b0, '0, '0, 2'b11, f);
        chk("stream_count", 64'(n_out - out_start), 64'd16);

        // Backpressure on ch0 while more words are offered for ch1.
        step(1'b1, 32'hA0A0A0A0, 3'd0, 2'b11, f);
        d = 32'hB0000001;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, d, 3'd1, 2'b10, f);
            if (f) d = d + 32'd1;
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 2'b11, f);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic, words held stable until accepted.
        pend = 1'b0; d = '0; s = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend) begin
                pend = ($urandom % 4) != 0;
                d    = $urandom;
                s    = (($urandom % 8) == 0) ? SEL_W'($urandom_range(2, 7)) : SEL_W'($urandom_range(0, 1));
            end
            r[0] = ($urandom % 4) != 0;
            r[1] = ($urandom % 4) != 0;
            step(pend, d, s, r, f);
            if (f) pend = 1'b0;
        end

        // Out-of-range flood: counter must saturate, no output appears.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, $urandom, SEL_W'($urandom_range(2, 7)), 2'b11, f);
        end
        step(1'b0, '0, '0, 2'b11, f);
        chk("drop_sat", 64'(bus.drop_cnt), 64'd255);

        // Reset while a word for ch1 is held and stalled.
        step(1'b1, 32'h00C0FFEE, 3'd1, 2'b01, f);
        step(1'b0, '0, '0, 2'b01, f);
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        drop_model = 0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;

        // Traffic after reset, then drain with a bounded wait.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h5000 + 32'(i), SEL_W'(i % 3), 2'(i % 4), f);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step(1'b0, '0, '0, 2'b11, f);
        end
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
